// File: rtl/iiitb_wm_pkg.sv
// Shared encodings for the iiitb_wm timing controller: timer states, phase decode, default widths.
package iiitb_wm_pkg;

  localparam int unsigned PreW = 16;
  localparam int unsigned DurW = 8;

  typedef enum logic [2:0] {
    TIdle  = 3'd0,
    TWash  = 3'd1,
    TRinse = 3'd2,
    TSpin  = 3'd3,
    TFill  = 3'd4,
    TDone  = 3'd5,
    TFault = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    PhNone  = 3'd0,
    PhWash  = 3'd1,
    PhRinse = 3'd2,
    PhSpin  = 3'd3,
    PhFill  = 3'd4
  } phase_e;

  // Motor phases take precedence over the valves when several actuators are on at once.
  function automatic phase_e decode_phase(input logic motor_on, input logic fill_on,
                                          input logic drain_on, input logic water_wash);
    phase_e ph;
    if (motor_on)                    ph = water_wash ? PhRinse : PhWash;
    else if (drain_on && water_wash) ph = PhSpin;
    else if (fill_on)                ph = PhFill;
    else                             ph = PhNone;
    return ph;
  endfunction

endpackage

// File: rtl/iiitb_wm_timer_if.sv
// Actuator/timeout signals exchanged between the washing-machine FSM and its timing controller.
interface iiitb_wm_timer_if;

  logic motor_on;
  logic fill_value_on;
  logic drain_value_on;
  logic water_wash;
  logic cycle_timeout;
  logic spin_timeout;

  modport master (
    output motor_on, fill_value_on, drain_value_on, water_wash,
    input  cycle_timeout, spin_timeout
  );

  modport slave (
    input  motor_on, fill_value_on, drain_value_on, water_wash,
    output cycle_timeout, spin_timeout
  );

endinterface

// File: rtl/iiitb_wm_prescaler.sv
// Tick generator: strobes once every max(div,1) clocks, realigned to zero by restart.
module iiitb_wm_prescaler #(
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PRE_W-1:0] div,
  input  logic             restart,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q, cnt_d, last;

  always_comb begin
    last  = (div == '0) ? '0 : div - 1'b1;
    // >= so a divider lowered mid-count wraps at once instead of running through the full range
    tick  = (cnt_q >= last);
    cnt_d = (restart || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/iiitb_wm_timer.sv
// Timing controller beside the iiitb_wm FSM: phase timeouts from programmable tick durations
// plus a sticky fill-valve watchdog fault.
module iiitb_wm_timer
  import iiitb_wm_pkg::*;
#(
  parameter int unsigned PRE_W = PreW,
  parameter int unsigned DUR_W = DurW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PRE_W-1:0]  prescale_div,
  input  logic [DUR_W-1:0]  wash_dur,
  input  logic [DUR_W-1:0]  rinse_dur,
  input  logic [DUR_W-1:0]  spin_dur,
  input  logic [DUR_W-1:0]  fill_limit,
  input  logic              fault_clr,
  iiitb_wm_timer_if.slave   bus,
  output logic              fault,
  output logic [2:0]        phase,
  output logic              tick
);

  state_e           st_q, st_d;
  phase_e           org_q, org_d, dec;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic             ptick, restart;
  logic             cyc_to_q, cyc_to_d, spin_to_q, spin_to_d, fault_q, fault_d, tick_q;

  assign dec     = decode_phase(bus.motor_on, bus.fill_value_on, bus.drain_value_on,
                                bus.water_wash);
  assign restart = (st_d != st_q);

  iiitb_wm_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .div     (prescale_div),
    .restart (restart),
    .tick    (ptick)
  );

  always_comb begin
    st_d  = st_q;
    org_d = org_q;
    cnt_d = cnt_q;
    unique case (st_q)
      TIdle: begin
        org_d = dec;
        case (dec)
          PhWash:  begin st_d = TWash;  cnt_d = wash_dur;   end
          PhRinse: begin st_d = TRinse; cnt_d = rinse_dur;  end
          PhSpin:  begin st_d = TSpin;  cnt_d = spin_dur;   end
          PhFill:  begin st_d = TFill;  cnt_d = fill_limit; end
          default: ;
        endcase
      end
      TWash, TRinse, TSpin: begin
        if (dec != org_q) begin
          st_d = TIdle;
        end else begin
          if (ptick && cnt_q != '0) cnt_d = cnt_q - 1'b1;
          if (cnt_d == '0) st_d = TDone;
        end
      end
      TDone: begin
        if (dec != org_q) st_d = TIdle;
      end
      TFill: begin
        // A zero count here means the watchdog was loaded disabled; it never counts.
        if (!bus.fill_value_on) begin
          st_d = TIdle;
        end else if (ptick && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DUR_W'(1)) st_d = TFault;
        end
      end
      TFault: begin
        if (fault_clr) st_d = TIdle;
      end
      default: st_d = TIdle;
    endcase

    cyc_to_d  = (st_d == TDone) && (org_d != PhSpin);
    spin_to_d = (st_d == TDone) && (org_d == PhSpin);
    fault_d   = (st_d == TFault);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= TIdle;
      org_q     <= PhNone;
      cnt_q     <= '0;
      cyc_to_q  <= 1'b0;
      spin_to_q <= 1'b0;
      fault_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      org_q     <= org_d;
      cnt_q     <= cnt_d;
      cyc_to_q  <= cyc_to_d;
      spin_to_q <= spin_to_d;
      fault_q   <= fault_d;
      tick_q    <= ptick;
    end
  end

  assign bus.cycle_timeout = cyc_to_q;
  assign bus.spin_timeout  = spin_to_q;
  assign fault             = fault_q;
  assign phase             = st_q;
  assign tick              = tick_q;

endmodule

// File: tb/tb_iiitb_wm_timer.sv
// Self-checking bench for iiitb_wm_timer: elapsed-time model checked every cycle plus directed
// scenarios with literal expectations.
module tb_iiitb_wm_timer;

  localparam int unsigned PRE_W = 16;
  localparam int unsigned DUR_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [PRE_W-1:0] prescale_div;
  logic [DUR_W-1:0] wash_dur, rinse_dur, spin_dur, fill_limit;
  logic             fault_clr;
  logic             fault, tick;
  logic [2:0]       phase;

  iiitb_wm_timer_if bus ();

  iiitb_wm_timer #(
    .PRE_W (PRE_W),
    .DUR_W (DUR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .prescale_div (prescale_div),
    .wash_dur     (wash_dur),
    .rinse_dur    (rinse_dur),
    .spin_dur     (spin_dur),
    .fill_limit   (fill_limit),
    .fault_clr    (fault_clr),
    .bus          (bus),
    .fault        (fault),
    .phase        (phase),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: state codes 0 idle,1 wash,2 rinse,3 spin,4 fill,5 done,6 fault.
  // Timing is elapsed clocks since entry: a phase of d ticks expires d*div clocks after entry
  // (d=0 expires on the first clock).
  int     cyc = 0;
  int     m_st = 0, m_org = 0, m_entry = 0;
  longint m_target = 0;
  bit     m_nolimit = 1'b0;
  bit     m_tick = 1'b0, m_tick_valid = 1'b0;

  function automatic int inputs_phase();
    if (bus.motor_on) return bus.water_wash ? 2 : 1;
    if (bus.drain_value_on && bus.water_wash) return 3;
    if (bus.fill_value_on) return 4;
    return 0;
  endfunction

  task automatic model_step();
    int old, dec, div, dur, prev;
    longint el;
    old = cyc;
    cyc++;
    if (!reset_n) begin
      m_st = 0; m_org = 0; m_tick = 1'b0; m_tick_valid = 1'b0; m_entry = cyc;
      return;
    end
    div          = (prescale_div == 0) ? 1 : int'(prescale_div);
    m_tick       = (((old - m_entry) % div) == div - 1);
    m_tick_valid = (m_st != 0);
    el           = longint'(cyc - m_entry);
    dec          = inputs_phase();
    prev         = m_st;
    case (m_st)
      0: if (dec != 0) begin
        dur = (dec == 1) ? int'(wash_dur) : (dec == 2) ? int'(rinse_dur) :
              (dec == 3) ? int'(spin_dur) : int'(fill_limit);
        m_st      = dec;
        m_org     = dec;
        m_target  = (dur == 0) ? 1 : longint'(dur) * div;
        m_nolimit = (dec == 4) && (dur == 0);
      end
      1, 2, 3: if (dec != m_st) m_st = 0; else if (el >= m_target) m_st = 5;
      4: if (!bus.fill_value_on) m_st = 0; else if (!m_nolimit && el >= m_target) m_st = 6;
      5: if (dec != m_org) m_st = 0;
      6: if (fault_clr) m_st = 0;
      default: m_st = 0;
    endcase
    if (m_st != prev) m_entry = cyc;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [5:0] exp_v;
    @(negedge clk);
    if (!reset_n) exp_v = '0;
    else exp_v = {m_st == 5 && m_org != 3, m_st == 5 && m_org == 3, m_st == 6, 3'(m_st)};
    check("outputs_vs_model", {bus.cycle_timeout, bus.spin_timeout, fault, phase}, exp_v);
    if (!reset_n) check("tick_in_reset", tick, 0);
    else if (m_tick_valid) check("tick_vs_model", tick, m_tick);
  end

  function automatic logic sel(input int w);
    case (w)
      0:       return bus.cycle_timeout;
      1:       return bus.spin_timeout;
      default: return fault;
    endcase
  endfunction

  task automatic wait_rise(input int which, input int limit, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!sel(which) && n < limit);
  endtask

  initial begin
    int n;
    bit seen;
    prescale_div = 4; wash_dur = 3; rinse_dur = 10; spin_dur = 0; fill_limit = 2;
    fault_clr = 1'b0;
    bus.motor_on = 1'b1; bus.water_wash = 1'b0;
    bus.fill_value_on = 1'b0; bus.drain_value_on = 1'b0;

    // Reset held with motor on
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.cycle_timeout, bus.spin_timeout, fault, phase, tick}, 0);
    reset_n = 1'b1;
    step(1);
    check("wash_entry_after_reset", phase, 1);
    bus.motor_on = 1'b0;
    step(2);
    check("idle_after_abort", phase, 0);

    // Soap wash: 3 ticks of 4 clocks
    bus.motor_on = 1'b1;
    wait_rise(0, 60, n);
    check("wash_timeout_latency", n, 13);
    step(3);
    check("wash_timeout_held", bus.cycle_timeout, 1);
    bus.motor_on = 1'b0;
    step(1);
    check("wash_timeout_falls", bus.cycle_timeout, 0);

    // Spin with zero duration and zero divider
    prescale_div = 0; bus.drain_value_on = 1'b1; bus.water_wash = 1'b1;
    wait_rise(1, 20, n);
    check("spin_timeout_latency", n, 2);
    bus.drain_value_on = 1'b0; bus.water_wash = 1'b0;
    step(2);
    check("spin_timeout_falls", bus.spin_timeout, 0);

    // Rinse aborted after 5 ticks
    prescale_div = 2; bus.motor_on = 1'b1; bus.water_wash = 1'b1;
    step(1);
    check("rinse_entry", phase, 2);
    step(10);
    check("rinse_still_running", phase, 2);
    bus.motor_on = 1'b0;
    step(1);
    check("rinse_abort_idle", phase, 0);
    seen = 1'b0;
    repeat (30) begin step(1); seen |= bus.cycle_timeout; end
    check("rinse_abort_no_timeout", seen, 0);
    bus.water_wash = 1'b0;

    // Fill watchdog trips, timeouts suppressed, cleared by fault_clr
    prescale_div = 1; fill_limit = 2; bus.fill_value_on = 1'b1;
    wait_rise(2, 20, n);
    check("fill_fault_latency", n, 3);
    bus.motor_on = 1'b1;
    step(5);
    check("fault_blocks_timeouts", {bus.cycle_timeout, bus.spin_timeout}, 0);
    check("fault_state", phase, 6);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("fault_cleared", fault, 0);
    check("fault_clear_idle", phase, 0);
    bus.motor_on = 1'b0; bus.fill_value_on = 1'b0;
    step(2);

    // Watchdog disabled
    fill_limit = 0; bus.fill_value_on = 1'b1;
    seen = 1'b0;
    repeat (1000) begin step(1); seen |= fault; end
    check("watchdog_disabled", seen, 0);
    check("watchdog_disabled_fill", phase, 4);
    bus.fill_value_on = 1'b0;
    step(1);

    // Fault set and clear in the same cycle: set wins
    fill_limit = 1; bus.fill_value_on = 1'b1;
    step(1);
    check("fill_entry", phase, 4);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("set_beats_clear", fault, 1);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0; bus.fill_value_on = 1'b0;
    step(1);
    check("fault_clear_again", {fault, phase}, 0);

    // Reset mid-phase
    prescale_div = 4; wash_dur = 5; bus.motor_on = 1'b1;
    step(10);
    check("wash_before_reset", phase, 1);
    reset_n = 1'b0;
    #1;
    check("async_reset_clears", {bus.cycle_timeout, bus.spin_timeout, fault, phase, tick}, 0);
    bus.motor_on = 1'b0;
    step(2);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin step(1); seen |= bus.cycle_timeout; end
    check("no_timeout_after_reset", seen, 0);

    // Mixed actuator traffic, checked by the model only
    prescale_div = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        {bus.motor_on, bus.water_wash, bus.drain_value_on, bus.fill_value_on} =
          4'($urandom_range(0, 15));
        wash_dur   = 8'($urandom_range(0, 4));
        rinse_dur  = 8'($urandom_range(0, 4));
        spin_dur   = 8'($urandom_range(0, 4));
        fill_limit = 8'($urandom_range(0, 3));
      end
      fault_clr = ($urandom_range(0, 15) == 0);
      step(1);
    end
    fault_clr = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
